// File: rtl/sram_pkg.sv
// Shared widths, constants and FSM encoding for the SRAM burst engine.
package sram_pkg;

  localparam int         SRAM_ADDR_W = 18;
  localparam int         SRAM_DATA_W = 16;
  localparam logic [1:0] SRAM_BE_ALL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; buffers read returns for the burst engine.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  // a pop frees the slot, so a push into a full FIFO is fine in the same cycle
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/sram_burst_engine.sv
// Splits a burst command into single-word sram_top requests; read returns are
// buffered in a credit-limited FIFO so it can never overflow.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | cmd_ready=1, waiting for a burst command
//   ST_WRITE | one request per write-stream word until remaining hits 0
//   ST_READ  | issue reads while words remain and FIFO credit is free
//   ST_DRAIN | all reads issued, waiting for the last return, then done
module sram_burst_engine
  import sram_pkg::*;
#(
  parameter int LEN_W         = 10,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rd,
  input  logic [SRAM_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SRAM_DATA_W-1:0] wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [SRAM_DATA_W-1:0] rd_data,
  output logic                   done,
  output logic                   sram_req,
  input  logic                   sram_ready,
  output logic                   sram_rd,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [1:0]             sram_be,
  output logic [SRAM_DATA_W-1:0] sram_wr_data,
  input  logic                   sram_rd_data_vld,
  input  logic [SRAM_DATA_W-1:0] sram_rd_data
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;
  localparam int REM_W = LEN_W + 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [REM_W-1:0]       r_remaining;
  logic [CNT_W-1:0]       r_outstanding;
  logic                   r_done;

  logic                   w_req;
  logic                   w_rd;
  logic                   w_finish;
  logic                   w_hs;
  logic                   w_last;
  logic                   w_ret;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_credit;
  logic [CNT_W:0]         w_inflight;
  logic [CNT_W-1:0]       w_fifo_count;
  logic                   w_fifo_empty;
  logic                   w_fifo_full;

  assign w_hs   = w_req && sram_ready;
  assign w_last = (r_remaining == REM_W'(1));

  // credit counts both words still in flight and words waiting in the FIFO
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit   = (w_inflight < (CNT_W + 1)'(RD_FIFO_DEPTH));

  // a return with nothing outstanding is a protocol error and is dropped
  assign w_ret  = sram_rd_data_vld && (r_outstanding != '0);
  assign w_pop  = rd_valid && rd_ready;
  assign w_push = w_ret && (!w_fifo_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_rd        = 1'b0;
    w_finish    = 1'b0;
    wr_ready    = 1'b0;
    cmd_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = cmd_rd ? ST_READ : ST_WRITE;
      end
      ST_WRITE: begin
        w_req    = wr_valid;
        wr_ready = wr_valid && sram_ready;
        if (w_hs && w_last) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      ST_READ: begin
        w_rd  = 1'b1;
        w_req = (r_remaining != '0) && w_credit;
        if (w_hs && w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((r_outstanding == '0) || ((r_outstanding == CNT_W'(1)) && w_ret)) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_finish;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_addr      <= cmd_addr;
        r_remaining <= {1'b0, cmd_len} + REM_W'(1);
      end else if (w_hs) begin
        r_addr      <= r_addr + SRAM_ADDR_W'(1);
        r_remaining <= r_remaining - REM_W'(1);
      end
      case ({w_hs && (r_state == ST_READ), w_ret})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (SRAM_DATA_W),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (sram_rd_data),
    .i_pop       (w_pop),
    .o_pop_data  (rd_data),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  assign rd_valid     = !w_fifo_empty;
  assign done         = r_done;
  assign sram_req     = w_req;
  assign sram_rd      = w_req && w_rd;
  assign sram_addr    = w_req ? r_addr : '0;
  assign sram_wr_data = (w_req && !w_rd) ? wr_data : '0;
  assign sram_be      = SRAM_BE_ALL;

endmodule

// File: doc/sram_burst_engine.md
Name: sram_burst_engine

Overview:
- Converts one burst command (start address, word count, direction) into a sequence of single-word requests on the sram_top request port.
- Sits directly upstream of sram_top, in the slot a pattern tester or host bridge would drive.
- Sources write data from a valid/ready stream.
- Returns read data on a valid/ready stream through an internal FIFO; reads are credit-limited so the FIFO can never overflow.

Parameters:
- LEN_W, 10, width of cmd_len; bursts of 1..2^LEN_W words.
- RD_FIFO_DEPTH, 4, read return FIFO depth (power of two, >=2); also the maximum number of reads in flight plus buffered.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  engine idle, command accepted when cmd_valid && cmd_ready
- cmd_rd  in  1  1 = read burst, 0 = write burst
- cmd_addr  in  18  start word address
- cmd_len  in  LEN_W  word count minus one
- wr_valid  in  1  write data word valid
- wr_ready  out  1  write word consumed
- wr_data  in  16  write data word
- rd_valid  out  1  read data word valid
- rd_ready  in  1  downstream accepts read word
- rd_data  out  16  read data word
- done  out  1  one-cycle pulse when burst fully complete
- sram_req  out  1  request to sram_top
- sram_ready  in  1  sram_top accepts request this cycle
- sram_rd  out  1  request is a read
- sram_addr  out  18  request word address
- sram_be  out  2  byte enables, always 2'b11
- sram_wr_data  out  16  write data for request
- sram_rd_data_vld  in  1  read return valid (in request order)
- sram_rd_data  in  16  read return data

Behaviour:
- Reset values:
  - State IDLE; cmd_ready=1.
  - sram_req=0, wr_ready=0, rd_valid=0, done=0.
  - All counters 0; FIFO empty.
  - sram_addr, sram_rd and sram_wr_data are 0 when sram_req=0.
- State machine:
  - IDLE: on cmd_valid && cmd_ready, latch addr, remaining = cmd_len + 1 and direction; go to WRITE or READ. cmd_ready=1 only in IDLE.
  - WRITE: sram_req = wr_valid; wr_ready = sram_ready && wr_valid; sram_wr_data = wr_data (combinational pass-through).
    - On handshake: addr+1, remaining-1.
    - On the last handshake: done=1 next cycle, then IDLE.
    - wr_valid low stalls the burst with no request issued.
  - READ: sram_req=1 while remaining!=0 and credit available, credit = (outstanding + fifo_count) < RD_FIFO_DEPTH.
    - On handshake: addr+1, remaining-1, outstanding+1.
    - After the last issue, go to DRAIN.
  - DRAIN: wait for outstanding==0, then pulse done and go to IDLE.
- Read return:
  - Each sram_rd_data_vld pushes sram_rd_data into the FIFO and decrements outstanding.
  - An issue and a return in the same cycle leave outstanding unchanged.
  - FIFO output drives rd_valid/rd_data; pop on rd_valid && rd_ready.
  - A push into an empty FIFO gives rd_valid=1 the next cycle (1-cycle latency).
- done timing: in a read burst, done fires when the last word enters the FIFO; the word may still be unpopped.
- Address arithmetic: 18-bit modulo; 18'h3FFFF + 1 wraps to 0 silently.
- Request stability: once sram_req is raised in READ, sram_req/addr/rd hold until sram_ready. In WRITE they follow wr_valid.
- Simultaneous events: FIFO push and pop in the same cycle keep the count unchanged and never report full.
- Protocol error: sram_rd_data_vld with outstanding==0 is a protocol error. The word is ignored and outstanding does not underflow.
- Mid-burst reset: returns to the reset values on the next edge. In-flight read returns after reset are dropped (outstanding==0 rule).

Decomposition:
- Package sram_pkg: SRAM_ADDR_W=18, SRAM_DATA_W=16, SRAM_BE_ALL=2'b11, state encoding (IDLE, WRITE, READ, DRAIN).
- One sub-module: sync_fifo (parameterised width/depth, push/pop/count/empty/full), used as the read return buffer.

Test Plan:
- Write burst: cmd addr=0x00010, len=3, wr stream 0xA000..0xA003 -> four sram requests at addrs 0x10..0x13 with matching data, be=2'b11, done one cycle after the 4th handshake.
- Read burst, rd_ready held 0: slave returning each read 2 cycles after accept, len=7 -> exactly 4 requests issued then sram_req=0; after rd_ready=1, all 8 words appear in order and done fires.
- Wrap: write cmd addr=0x3FFFE, len=3 -> addrs 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- Stalls: write burst with wr_valid toggling every other cycle and sram_ready low for 3 cycles -> no duplicated or skipped addresses; req/addr stable while sram_ready low.
- Single word: read len=0 at addr 0x00005 -> one request, rd_data equals slave data, done pulse; cmd_ready=1 again the following cycle.
- Reset mid-read: 2 reads outstanding, assert reset for 1 cycle -> all outputs at reset values; late sram_rd_data_vld ignored, rd_valid stays 0.
